uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- User-project UART receiver. Deserialises 8N1 frames arriving on mprj_io[5] (driven by the bench UART's ser_tx) and buffers the bytes in a small FIFO.
- A valid/ready handshake presents the bytes to the user-project Wishbone/CPU side.
- Sticky frame-error and overrun flags report line faults.
- It is the receive end of the serial link that the bench transmitter drives.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Legal range 8..65535. Silicon value is 4167 (40 MHz, 9600 baud).
- FIFO_DEPTH, 4: receive FIFO entries. Power of 2, range 2..16.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- rx, input, 1: serial line, idle high, asynchronous to clk.
- rx_data, output, 8: byte at the FIFO head.
- rx_valid, output, 1: FIFO not empty.
- rx_ready, input, 1: consumer accepts the head byte.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: occupancy.
- frame_err, output, 1: sticky, stop bit sampled low.
- overrun, output, 1: sticky, byte dropped because the FIFO was full.
- err_clr, input, 1: one-cycle pulse that clears frame_err and overrun.
- rx_busy, output, 1: high while the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM IDLE, counters 0, FIFO empty.
  - Outputs at reset: rx_data=8'h00, rx_valid=0, fifo_count=0, frame_err=0, overrun=0, rx_busy=0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame abandons the partial byte; nothing is pushed.
- rx passes through a 2-flop synchroniser; rx_s is its output. All line sampling uses rx_s.
- FSM states:
  - IDLE: on rx_s==0, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample. If rx_s==1, treat as a glitch and return to IDLE with no push. If rx_s==0, go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample one bit. LSB first; shift into bit 7 and shift right. After 8 samples go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rx_s==1: push the byte.
    - rx_s==0: set frame_err and discard the byte.
    - Either way go to IDLE. Back-to-back frames are accepted immediately after the stop sample.
- Latency: a byte is visible on rx_data/rx_valid 1 cycle after the stop-bit sample (registered push).
- Handshake:
  - A pop occurs when rx_valid && rx_ready. The next entry appears the following cycle.
  - rx_data holds its value while rx_valid=1 and rx_ready=0.
  - rx_data is don't-care when rx_valid=0, but must not be X after reset.
- Full FIFO:
  - Push with no pop in the same cycle: the byte is dropped, overrun is set, and the FIFO contents are unchanged.
  - Push and pop in the same cycle: both occur, count is unchanged, no overrun.
- Empty FIFO: rx_ready is ignored and count stays 0.
- Pointers wrap modulo FIFO_DEPTH. Count is an explicit register: +1 on push only, -1 on pop only.
- Error flags:
  - err_clr and a new error set in the same cycle: set wins.
  - Errors never block reception.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frames are 8E1; an even parity bit follows the 8 data bits.
  - FSM gains a PARITY state between DATA and STOP, sampled after CLKS_PER_BIT cycles.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by err_clr with set-wins).
  - On parity mismatch, parity_err is set and the byte is discarded, even if the stop bit is good. If the stop bit is also bad, both flags set.
- Undefined:
  - 8N1 only; no PARITY state.
  - parity_err port does not exist.

Test Plan:
- Reset, then send 8'h0F, 8'h3D, 8'h10, 8'h33 back-to-back with rx_ready=1 -> four pops in order, each value correct, frame_err=0, overrun=0, fifo_count returns to 0.
- rx_ready=0, send 5 bytes 8'h01..8'h05 (FIFO_DEPTH=4) -> fifo_count=4, overrun=1 after the 5th stop bit; popping yields 01,02,03,04; then rx_valid=0.
- Send 8'hA5 with stop bit forced low -> frame_err=1, no push (fifo_count=0). Pulse err_clr -> frame_err=0. Next good frame 8'h5A is received correctly.
- Low glitch on rx lasting CLKS_PER_BIT/4 cycles -> FSM returns to IDLE, no push, rx_busy drops within CLKS_PER_BIT/2+3 cycles.
- Assert rst_n=0 during the data bits of 8'hFF -> all outputs at reset values immediately. After release, frame 8'h42 is received correctly with no stale byte.
- UART_RX_PARITY_EN defined:
  - 8'h07 sent with parity bit 0 (wrong) -> parity_err=1, no push.
  - 8'h07 sent with parity bit 1 -> byte accepted, parity_err unchanged.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO and valid/ready read side.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check and parity_err output.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          rx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   BIT_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   HALF_LAST  = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic [2:0]    r_state;
  logic [15:0]   r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_frame_err;
  logic          r_overrun;

  logic w_rx_s;
  logic w_stop_tick;
  logic w_par_ok;
  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_do_push;
  logic w_set_ovr;
  logic w_set_ferr;

  assign w_rx_s = r_sync2;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  logic w_set_perr;

  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction

  assign w_par_ok   = (r_par_bit == even_parity(r_shift));
  assign w_set_perr = w_stop_tick && !w_par_ok;
  assign parity_err = r_parity_err;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_stop_tick = (r_state == S_STOP) && (r_clk_cnt == BIT_LAST);
  assign w_push_req  = w_stop_tick && w_rx_s && w_par_ok;
  assign w_set_ferr  = w_stop_tick && !w_rx_s;
  assign w_full      = (r_count == FULL_COUNT);
  assign w_pop       = (r_count != {CW{1'b0}}) && rx_ready;
  // A full FIFO still takes the new byte when the head leaves in the same cycle.
  assign w_do_push   = w_push_req && (!w_full || w_pop);
  assign w_set_ovr   = w_push_req && w_full && !w_pop;

  assign rx_data    = r_mem[r_rd_ptr];
  assign rx_valid   = (r_count != {CW{1'b0}});
  assign fifo_count = r_count;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign rx_busy    = (r_state != S_IDLE);

  // Two-flop synchroniser, idle-high reset so no false start bit after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: mid-bit sampling of start, data, optional parity and stop bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= 16'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state   <= S_START;
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
          end
        end
        S_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= 16'd0;
            r_state   <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= 16'd0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= 16'd0;
            r_par_bit <= w_rx_s;
            r_state   <= S_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= 16'd0;
            r_state   <= S_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= 16'd0;
        end
      endcase
    end
  end

  // FIFO storage and pointers; entries reset to zero so rx_data is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CW{1'b0}};
    end else begin
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= w_set_ferr ? 1'b1 : (err_clr ? 1'b0 : r_frame_err);
      r_overrun   <= w_set_ovr  ? 1'b1 : (err_clr ? 1'b0 : r_overrun);
`ifdef UART_RX_PARITY_EN
      r_parity_err <= w_set_perr ? 1'b1 : (err_clr ? 1'b0 : r_parity_err);
`endif
    end
  end

endmodule
